// File: rtl/phys_free_list.sv
// Physical register free list: circular FIFO of free pregs with a speculative head,
// a committed head for full flush recovery, and branch checkpoints of the speculative head.
module phys_free_list #(
    parameter int NUM_PHYS_REGS = 48,
    parameter int NUM_ARCH_REGS = 32,
    parameter int PREG_WIDTH    = 6,
    parameter int CKPT_NUM      = 4,
    localparam int DEPTH        = NUM_PHYS_REGS - NUM_ARCH_REGS,
    localparam int IDX_W        = $clog2(DEPTH),
    localparam int PTR_W        = IDX_W + 1,
    localparam int CKPT_W       = (CKPT_NUM > 1) ? $clog2(CKPT_NUM) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alloc_req,
    output logic                  alloc_valid,
    output logic [PREG_WIDTH-1:0] alloc_preg,
    input  logic                  commit_pop,
    input  logic                  free_req,
    input  logic [PREG_WIDTH-1:0] free_preg,
    input  logic                  flush,
    input  logic                  ckpt_save,
    output logic [CKPT_W-1:0]     ckpt_id,
    output logic                  ckpt_avail,
    input  logic                  ckpt_restore,
    input  logic [CKPT_W-1:0]     ckpt_restore_id,
    input  logic                  ckpt_release,
    input  logic [CKPT_W-1:0]     ckpt_release_id,
    output logic                  empty,
    output logic [PTR_W-1:0]      count,
    output logic                  overflow_err
);

    logic [PREG_WIDTH-1:0] mem_q [DEPTH];
    logic [PREG_WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]      spec_head_q, spec_head_d;
    logic [PTR_W-1:0]      commit_head_q, commit_head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic                  overflow_q, overflow_d;

    logic [CKPT_NUM-1:0]   ckpt_valid_q, ckpt_valid_d;
    logic [PTR_W-1:0]      ckpt_head_q [CKPT_NUM];
    logic [PTR_W-1:0]      ckpt_head_d [CKPT_NUM];
    // younger_q[i][j] set means slot j was saved while slot i was live
    logic [CKPT_NUM-1:0]   ckpt_younger_q [CKPT_NUM];
    logic [CKPT_NUM-1:0]   ckpt_younger_d [CKPT_NUM];

    logic                  full;
    logic                  restore_hit;
    logic                  save_en;
    logic [PTR_W-1:0]      spec_after_alloc;
    logic [CKPT_NUM-1:0]   kill_mask;

    always_comb begin
        count        = tail_q - spec_head_q;
        empty        = (count == '0);
        full         = (tail_q[IDX_W] != spec_head_q[IDX_W]) &&
                       (tail_q[IDX_W-1:0] == spec_head_q[IDX_W-1:0]);
        restore_hit  = ckpt_restore && ckpt_valid_q[ckpt_restore_id];
        alloc_valid  = alloc_req && !empty && !flush && !restore_hit && !rst;
        alloc_preg   = mem_q[spec_head_q[IDX_W-1:0]];
        ckpt_avail   = ~&ckpt_valid_q;
        overflow_err = overflow_q;
        ckpt_id      = '0;
        for (int i = CKPT_NUM - 1; i >= 0; i--) begin
            if (!ckpt_valid_q[i]) begin
                ckpt_id = CKPT_W'(i);
            end
        end
        save_en          = ckpt_save && ckpt_avail && !flush && !restore_hit && !rst;
        spec_after_alloc = spec_head_q + {{(PTR_W-1){1'b0}}, alloc_valid};
    end

    // Tail side and commit head run every cycle, independent of recovery
    always_comb begin
        mem_d         = mem_q;
        tail_d        = tail_q;
        overflow_d    = overflow_q;
        commit_head_d = commit_head_q + {{(PTR_W-1){1'b0}}, commit_pop};
        if (free_req) begin
            if (full) begin
                overflow_d = 1'b1;
            end else begin
                mem_d[tail_q[IDX_W-1:0]] = free_preg;
                tail_d                   = tail_q + 1'b1;
            end
        end
    end

    always_comb begin
        spec_head_d = spec_after_alloc;
        if (flush) begin
            spec_head_d = commit_head_d;
        end else if (restore_hit) begin
            spec_head_d = ckpt_head_q[ckpt_restore_id];
        end
    end

    always_comb begin
        ckpt_valid_d   = ckpt_valid_q;
        ckpt_head_d    = ckpt_head_q;
        ckpt_younger_d = ckpt_younger_q;
        kill_mask      = ckpt_younger_q[ckpt_restore_id];
        kill_mask[ckpt_restore_id] = 1'b1;

        if (ckpt_release) begin
            ckpt_valid_d[ckpt_release_id]   = 1'b0;
            ckpt_younger_d[ckpt_release_id] = '0;
            for (int i = 0; i < CKPT_NUM; i++) begin
                ckpt_younger_d[i][ckpt_release_id] = 1'b0;
            end
        end

        if (flush) begin
            ckpt_valid_d = '0;
            for (int i = 0; i < CKPT_NUM; i++) begin
                ckpt_younger_d[i] = '0;
            end
        end else if (restore_hit) begin
            // Drop the restored slot and everything saved after it
            ckpt_valid_d = ckpt_valid_d & ~kill_mask;
            for (int i = 0; i < CKPT_NUM; i++) begin
                ckpt_younger_d[i] = kill_mask[i] ? '0 : (ckpt_younger_d[i] & ~kill_mask);
            end
        end else if (save_en) begin
            ckpt_head_d[ckpt_id]    = spec_after_alloc;
            ckpt_valid_d[ckpt_id]   = 1'b1;
            ckpt_younger_d[ckpt_id] = '0;
            for (int i = 0; i < CKPT_NUM; i++) begin
                if (ckpt_valid_d[i] && (i != int'(ckpt_id))) begin
                    ckpt_younger_d[i][ckpt_id] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= PREG_WIDTH'(NUM_ARCH_REGS + i);
            end
            spec_head_q   <= '0;
            commit_head_q <= '0;
            tail_q        <= {1'b1, {IDX_W{1'b0}}};
            overflow_q    <= 1'b0;
            ckpt_valid_q  <= '0;
            for (int i = 0; i < CKPT_NUM; i++) begin
                ckpt_head_q[i]    <= '0;
                ckpt_younger_q[i] <= '0;
            end
        end else begin
            mem_q          <= mem_d;
            spec_head_q    <= spec_head_d;
            commit_head_q  <= commit_head_d;
            tail_q         <= tail_d;
            overflow_q     <= overflow_d;
            ckpt_valid_q   <= ckpt_valid_d;
            ckpt_head_q    <= ckpt_head_d;
            ckpt_younger_q <= ckpt_younger_d;
        end
    end

endmodule

// File: doc/phys_free_list.md
PHYS_FREE_LIST -- requirements
Module: phys_free_list

Interface
REQ-001 SHALL have parameter NUM_PHYS_REGS, default 48, meaning total physical registers.
REQ-002 SHALL have parameter NUM_ARCH_REGS, default 32, meaning architectural registers; DEPTH = NUM_PHYS_REGS - NUM_ARCH_REGS, power of two, at least 2.
REQ-003 SHALL have parameter PREG_WIDTH, default 6, meaning physical register index width.
REQ-004 SHALL have parameter CKPT_NUM, default 4, meaning branch checkpoint slots; CKPT_W = $clog2(CKPT_NUM).
REQ-005 SHALL use one clock; reset is synchronous and active-high: clk  in  1  clock, all state on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 alloc_req  in  1  dispatch requests one free preg.
REQ-008 alloc_valid  out  1  combinational; preg granted this cycle (alloc_req and not empty and not flush).
REQ-009 alloc_preg  out  PREG_WIDTH  entry at spec head; valid only when alloc_valid.
REQ-010 commit_pop  in  1  ROB commits an instruction that allocated; advances commit head.
REQ-011 free_req  in  1  ROB commit releases old mapping.
REQ-012 free_preg  in  PREG_WIDTH  preg written at tail when free_req.
REQ-013 flush  in  1  full mispredict recovery to committed state.
REQ-014 ckpt_save  in  1  snapshot spec head for a dispatched control instruction.
REQ-015 ckpt_id  out  CKPT_W  slot used by ckpt_save this cycle.
REQ-016 ckpt_avail  out  1  at least one slot free.
REQ-017 ckpt_restore  in  1  roll back to slot ckpt_restore_id.
REQ-018 ckpt_restore_id  in  CKPT_W  slot to restore.
REQ-019 ckpt_release  in  1  control instruction resolved correctly; frees slot ckpt_release_id.
REQ-020 ckpt_release_id  in  CKPT_W  slot to release.
REQ-021 empty  out  1  no free preg (count == 0).
REQ-022 count  out  $clog2(DEPTH)+1  free entries = tail - spec_head.
REQ-023 overflow_err  out  1  sticky; set by free_req while count == DEPTH.

Function
REQ-024 Storage SHALL be a DEPTH-entry circular buffer; spec_head, commit_head, tail SHALL be $clog2(DEPTH)+1 bits with a wrap bit; index = low bits.
REQ-025 alloc_valid SHALL advance spec_head by 1; no same-cycle bypass of free_preg to alloc_preg (empty blocks alloc even if free_req).
REQ-026 free_req with count < DEPTH SHALL write free_preg at tail and advance tail; with count == DEPTH SHALL be dropped and set overflow_err.
REQ-027 commit_pop SHALL advance commit_head; free_req and tail update SHALL proceed in every cycle regardless of flush/restore.
REQ-028 flush SHALL set spec_head = commit_head (plus commit_pop same cycle), clear all checkpoint valid bits, suppress alloc_valid and ckpt_save; highest priority.
REQ-029 ckpt_save with ckpt_avail SHALL store spec_head value after this cycle's allocation into lowest free slot, output that slot on ckpt_id, mark valid; ckpt_save when not ckpt_avail SHALL be ignored.
REQ-030 ckpt_restore on a valid slot SHALL set spec_head to the saved value, invalidate that slot and every slot saved after it (age tracked by a per-slot younger-than bitmap), suppress alloc_valid and ckpt_save that cycle; restore of invalid slot SHALL be ignored.
REQ-031 ckpt_release SHALL clear the slot's valid bit and its age bits; release and restore of same slot same cycle: restore wins.
REQ-032 Priority per cycle: flush > ckpt_restore > (alloc, ckpt_save); ckpt_release and free_req always apply.
REQ-033 Pointer wrap SHALL be by natural overflow; full = wrap bits differ and index equal.

Reset
REQ-034 On rst: entry i = NUM_ARCH_REGS + i, spec_head = commit_head = 0, tail = wrap bit 1/index 0 (count = DEPTH), all checkpoints invalid, overflow_err = 0; outputs: alloc_valid 0, empty 0, count DEPTH, ckpt_avail 1, ckpt_id 0.
REQ-035 rst asserted mid-operation SHALL override all other inputs that cycle.

Verification
REQ-036 After reset, 16 consecutive alloc_req -> alloc_preg 32..47 in order, then empty = 1, alloc_valid = 0 on 17th.
REQ-037 Empty, free_req preg 40 with alloc_req same cycle -> alloc_valid 0; next cycle alloc_preg 40, count 1->0.
REQ-038 Alloc 3 (32,33,34), commit_pop once, flush -> count 15, next alloc_preg 33.
REQ-039 Alloc 32, ckpt_save (id 0), alloc 33,34, ckpt_save (id 1), alloc 35, ckpt_restore 0 -> next alloc_preg 33, slots 0 and 1 invalid, ckpt_avail 1.
REQ-040 Save 4 checkpoints -> ckpt_avail 0, 5th save ignored; ckpt_release 2 -> ckpt_avail 1, next save ckpt_id 2.
REQ-041 After reset, free_req preg 5 -> overflow_err 1 sticky, count stays 16; 20 alloc/free pairs wrap pointers with FIFO order preserved.
